mvm_dot8_sched: RTL and testbench
=================================

Name: mvm_dot8_sched

Overview:
Sequencer and accumulator wrapped around one dot8 lane group for matrix-vector multiply. On a start pulse it walks a row-major matrix in 8-element chunks and issues read addresses to the vector and matrix memories. It drives dot8's ivalid aligned to memory read latency, accumulates per-chunk dot8 results into one sum per row, and buffers row sums in an output FIFO with valid/ready handshake. Credit-based row admission means the non-stallable dot8 pipeline never overruns the FIFO.

Parameters:
ADDRW, 9, width of vec_raddr and mat_raddr
ROWW, 8, width of cfg_rows
CHW, 6, width of cfg_chunks
MEM_LAT, 1, cycles from rd_en to data valid at dot8 inputs (must be >= 1)
OWIDTH, 32, dot8 result width and accumulator/out_data width
OFIFO_DEPTH, 4, output FIFO entries (power of two, >= 2)

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle job start; ignored while busy=1
cfg_rows  in  ROWW  rows in job, sampled on accepted start
cfg_chunks  in  CHW  8-element chunks per row, sampled on accepted start
busy  out  1  job in progress
done  out  1  one-cycle pulse, job complete
rd_en  out  1  read strobe to both memories
vec_raddr  out  ADDRW  vector chunk address
mat_raddr  out  ADDRW  matrix chunk address
dot_ivalid  out  1  to dot8 ivalid
dot_result  in  OWIDTH  from dot8 result
dot_ovalid  in  1  from dot8 ovalid
out_data  out  OWIDTH  row sum at FIFO head
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. All outputs are 0 after reset. FSM goes to IDLE. Counters, accumulator, FIFO pointers and the dot_ivalid delay line clear. Credits load OFIFO_DEPTH. Reset mid-job aborts the job; no done pulse and FIFO contents are lost. dot8 shares rst, so no stale dot_ovalid arrives.
- FSM states are IDLE, ISSUE and WAIT.
- IDLE: on start, latch cfg, clear row/chunk/linear counters and set busy=1.
  - If cfg_rows==0 or cfg_chunks==0: pulse done next cycle, busy drops the same cycle, no reads issued.
  - Otherwise go to ISSUE.
- ISSUE: each cycle may issue one chunk read.
  - rd_en=1, vec_raddr=chunk index, mat_raddr=linear counter (row*cfg_chunks+chunk). The linear counter increments per issue and wraps mod 2^ADDRW.
  - Before chunk 0 of any row, credits must be >0, otherwise rd_en=0 (stall). Issuing chunk 0 decrements credits.
  - Chunks 1..cfg_chunks-1 of a row issue back-to-back with no gaps.
  - After the last chunk of the last row, go to WAIT.
- WAIT: stay until the final row sum is written to the FIFO, then go to IDLE. done=1 for that one cycle and busy=0 from that cycle.
- dot_ivalid equals rd_en delayed exactly MEM_LAT cycles (shift register).
- Result side, independent of the FSM: a result-chunk counter advances on each dot_ovalid.
  - Chunk 0 loads acc=dot_result; other chunks do acc+=dot_result.
  - Width is OWIDTH, two's-complement, wraps with no saturation.
  - On the last chunk, acc+dot_result is written to the FIFO, the counter resets and rows_done increments.
  - When cfg_chunks==1, every dot_ovalid writes the FIFO directly.
- FIFO: out_valid=!empty and out_data=head, both registered. Pop on out_valid&&out_ready, which returns one credit the same cycle.
  - Credits are conserved: credits + rows in flight + FIFO occupancy == OFIFO_DEPTH. Hence push never occurs when full.
  - Simultaneous push and pop when full or empty is legal; occupancy stays consistent.
  - out_valid rises the cycle after the push.
- The FIFO may still hold rows after done. A new start is accepted next cycle, and credits carry over.
- start while busy is ignored with no side effects.

Test Plan:
- MEM_LAT=1, rows=1, chunks=1, all lanes a=b=1 (dot8 returns 8): start@0 -> rd_en@1 with addrs 0/0, dot_ivalid@2, out_data=8 one cycle after dot_ovalid, done the same cycle as the push, out_ready=1 pops it.
- rows=2, chunks=3, dot_result per chunk 5,-7,100 then -1,-1,-1: out_data 98 then -3; mat_raddr sequence 0..5 and vec_raddr 0,1,2,0,1,2, back-to-back.
- Backpressure: OFIFO_DEPTH=4, rows=6, chunks=2, out_ready=0: exactly 4 rows issued, rd_en held 0 and busy=1. Raising out_ready resumes issue one row per pop, all 6 sums delivered in order, done once.
- Overflow: chunks=2, results 0x7FFFFFFF and 1 -> out_data 0x80000000.
- cfg_rows=0 -> done one cycle after start, rd_en never asserted. Start pulsed mid-job -> ignored, outputs unchanged.
- rst asserted in ISSUE with 2 sums in the FIFO -> next cycle all outputs 0, out_valid=0. A new job afterwards completes with correct sums.

Source files
------------

// File: rtl/mvm_dot8_sched.sv
// mvm_dot8_sched: sequencer and accumulator around one dot8 lane group.
//
// A job computes one sum per matrix row. Each row is read as cfg_chunks chunks
// of 8 elements, so a job issues cfg_rows * cfg_chunks chunk reads. Finished row
// sums are queued in a small output FIFO with a valid/ready handshake.
//
// The dot8 pipeline cannot be stalled. A credit counter therefore admits a new
// row only when a FIFO slot is reserved for its result, so the FIFO never
// overflows.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   start                     one-cycle job start (ignored while a job runs)
//   cfg_rows, cfg_chunks      job shape, sampled when start is accepted
//   busy, done                job in progress / one-cycle completion pulse
//   rd_en                     read strobe to the vector and matrix memories
//   vec_raddr, mat_raddr      vector chunk address / matrix chunk address
//   dot_ivalid                rd_en delayed by MEM_LAT cycles, to dot8
//   dot_result, dot_ovalid    chunk result from dot8
//   out_data, out_valid       row sum at the FIFO head / FIFO non-empty
//   out_ready                 consumer accepts out_data
module mvm_dot8_sched #(
  parameter int unsigned ADDRW       = 9,
  parameter int unsigned ROWW        = 8,
  parameter int unsigned CHW         = 6,
  parameter int unsigned MEM_LAT     = 1,
  parameter int unsigned OWIDTH      = 32,
  parameter int unsigned OFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROWW-1:0]   cfg_rows,
  input  logic [CHW-1:0]    cfg_chunks,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDRW-1:0]  vec_raddr,
  output logic [ADDRW-1:0]  mat_raddr,
  output logic              dot_ivalid,
  input  logic [OWIDTH-1:0] dot_result,
  input  logic              dot_ovalid,
  output logic [OWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned PW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(OFIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [ROWW-1:0]   rows_q;
  logic [CHW-1:0]    chunks_q;
  logic [ROWW-1:0]   row_q;
  logic [CHW-1:0]    chunk_q;
  logic [ADDRW-1:0]  lin_q;
  logic [CW-1:0]     credits_q;
  logic [MEM_LAT-1:0] iv_sr_q, iv_sr_d;
  logic [CHW-1:0]    res_chunk_q;
  logic [OWIDTH-1:0] acc_q;
  logic [ROWW-1:0]   rows_done_q;
  logic [OWIDTH-1:0] fifo_q [OFIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic              start_ok, job_empty, issue, issue_first;
  logic              last_chunk, last_row, res_last, push, pop, last_push;
  logic [OWIDTH-1:0] acc_sum;

  assign start_ok    = start && (state_q == StIdle);
  assign job_empty   = (rows_q == '0) || (chunks_q == '0);
  assign last_chunk  = (chunk_q == chunks_q - CHW'(1));
  assign last_row    = (row_q == rows_q - ROWW'(1));
  // Chunk 0 of a row needs a credit; the remaining chunks of that row never stall.
  assign issue       = (state_q == StIssue) && ((chunk_q != '0) || (credits_q != '0));
  assign issue_first = issue && (chunk_q == '0);

  assign rd_en     = issue;
  assign vec_raddr = ADDRW'(chunk_q);
  assign mat_raddr = lin_q;

  // Result side: chunk 0 restarts the row sum, the last chunk pushes it.
  assign res_last  = (res_chunk_q == chunks_q - CHW'(1));
  assign acc_sum   = (res_chunk_q == '0) ? dot_result : acc_q + dot_result;
  assign push      = dot_ovalid && res_last;
  assign last_push = push && (rows_done_q == rows_q - ROWW'(1));

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = ((cfg_rows == '0) || (cfg_chunks == '0)) ? StWait : StIssue;
        end
      end
      StIssue: begin
        if (issue && last_chunk && last_row) state_d = StWait;
      end
      StWait: begin
        // An empty job finishes immediately; otherwise wait for the final row push.
        if (job_empty || last_push) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy = (state_q != StIdle) && !done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rows_q    <= '0;
      chunks_q  <= '0;
      row_q     <= '0;
      chunk_q   <= '0;
      lin_q     <= '0;
      credits_q <= CW'(OFIFO_DEPTH);
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        rows_q   <= cfg_rows;
        chunks_q <= cfg_chunks;
        row_q    <= '0;
        chunk_q  <= '0;
        lin_q    <= '0;
      end else if (issue) begin
        lin_q <= lin_q + ADDRW'(1);
        if (last_chunk) begin
          chunk_q <= '0;
          row_q   <= row_q + ROWW'(1);
        end else begin
          chunk_q <= chunk_q + CHW'(1);
        end
      end
      // A credit is taken when a row is admitted and returned when its sum leaves.
      case ({issue_first, pop})
        2'b10:   credits_q <= credits_q - CW'(1);
        2'b01:   credits_q <= credits_q + CW'(1);
        default: ;
      endcase
    end
  end

  // dot_ivalid tracks rd_en through the memory read latency.
  if (MEM_LAT == 1) begin : g_lat_one
    assign iv_sr_d = rd_en;
  end else begin : g_lat_multi
    assign iv_sr_d = {iv_sr_q[MEM_LAT-2:0], rd_en};
  end

  always_ff @(posedge clk) begin
    if (rst) iv_sr_q <= '0;
    else     iv_sr_q <= iv_sr_d;
  end

  assign dot_ivalid = iv_sr_q[MEM_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      res_chunk_q <= '0;
      acc_q       <= '0;
      rows_done_q <= '0;
    end else begin
      if (start_ok) rows_done_q <= '0;
      if (dot_ovalid) begin
        if (res_last) begin
          res_chunk_q <= '0;
          rows_done_q <= rows_done_q + ROWW'(1);
        end else begin
          res_chunk_q <= res_chunk_q + CHW'(1);
          acc_q       <= acc_sum;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OFIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= acc_sum;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_dot8_sched.sv
// Bench for mvm_dot8_sched: a one-cycle dot8 stand-in replays directed chunk
// results, and a negedge monitor logs reads, ivalid, done, and popped sums
// with cycle stamps for the scenario tasks to check.
module tb_mvm_dot8_sched;
  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [7:0]  cfg_rows;
  logic [5:0]  cfg_chunks;
  logic        busy, done, rd_en, dot_ivalid, out_valid;
  logic [8:0]  vec_raddr, mat_raddr;
  logic [31:0] out_data;
  logic [31:0] dot_result = '0;
  logic        dot_ovalid = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int s_cyc = 0;

  int          rd_cyc[$];
  int          rd_vec[$];
  int          rd_mat[$];
  int          iv_cyc[$];
  int          done_cyc[$];
  int          ovr_cyc[$];
  logic [31:0] pop_dat[$];
  logic [31:0] res_vals[$];
  int          res_idx = 0;
  logic        dv_q    = 1'b0;
  logic        ov_prev = 1'b0;

  always #5 clk = ~clk;

  mvm_dot8_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_rows   (cfg_rows),
    .cfg_chunks (cfg_chunks),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .vec_raddr  (vec_raddr),
    .mat_raddr  (mat_raddr),
    .dot_ivalid (dot_ivalid),
    .dot_result (dot_result),
    .dot_ovalid (dot_ovalid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // dot8 stand-in (ivalid in cycle k gives ovalid in cycle k+1), then the monitor.
  always @(negedge clk) begin
    if (rst) begin
      dv_q       = 1'b0;
      dot_ovalid = 1'b0;
      res_idx    = res_vals.size();
      ov_prev    = 1'b0;
    end else begin
      dot_ovalid = dv_q;
      if (dv_q) begin
        dot_result = (res_idx < res_vals.size()) ? res_vals[res_idx] : 32'h0;
        res_idx++;
      end
      dv_q = dot_ivalid;
      #1;
      if (rd_en) begin
        rd_cyc.push_back(cyc);
        rd_vec.push_back(int'(vec_raddr));
        rd_mat.push_back(int'(mat_raddr));
      end
      if (dot_ivalid) iv_cyc.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
      if (out_valid && !ov_prev) ovr_cyc.push_back(cyc);
      ov_prev = out_valid;
      if (out_valid && out_ready) pop_dat.push_back(out_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int rows, input int chunks);
    cfg_rows   = 8'(rows);
    cfg_chunks = 6'(chunks);
    start      = 1'b1;
    s_cyc      = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int db, input int limit);
    int k = 0;
    while (done_cyc.size() == db && k < limit) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (done_cyc.size() == db) begin
      n_bad++;
      $display("FAIL wait_done: got 0 done pulses after %0d cycles, want 1", limit);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; cfg_rows = '0; cfg_chunks = '0;
    tick(3);
    n_cmp++;
    if ({busy, done, rd_en, dot_ivalid, out_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, rd_en, dot_ivalid, out_valid});
    end
    n_cmp++;
    if ({out_data, vec_raddr, mat_raddr} !== 50'h0) begin
      n_bad++;
      $display("FAIL reset_data: got data %h vec %0d mat %0d want 0", out_data, vec_raddr,
               mat_raddr);
    end
    rst = 1'b0;
    tick(2);
    n_cmp++;
    if ({busy, out_valid} !== 2'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy/out_valid %b want 00", {busy, out_valid});
    end
  endtask

  task automatic test_single;
    int rb = rd_cyc.size();
    int ib = iv_cyc.size();
    int db = done_cyc.size();
    int vb = ovr_cyc.size();
    int pb = pop_dat.size();
    out_ready = 1'b1;
    res_vals.push_back(32'd8);
    do_start(1, 1);
    wait_done(db, 50);
    tick(3);
    n_cmp++;
    if (rd_cyc.size() - rb != 1 || rd_cyc[rb] != s_cyc + 1) begin
      n_bad++;
      $display("FAIL single_rd: got %0d reads first at +%0d, want 1 at +1", rd_cyc.size() - rb,
               rd_cyc[rb] - s_cyc);
    end
    n_cmp++;
    if (rd_vec[rb] != 0 || rd_mat[rb] != 0) begin
      n_bad++;
      $display("FAIL single_addr: got vec %0d mat %0d want 0/0", rd_vec[rb], rd_mat[rb]);
    end
    n_cmp++;
    if (iv_cyc.size() - ib != 1 || iv_cyc[ib] != s_cyc + 2) begin
      n_bad++;
      $display("FAIL single_ivalid: got at +%0d want +2", iv_cyc[ib] - s_cyc);
    end
    n_cmp++;
    if (done_cyc.size() - db != 1 || done_cyc[db] != s_cyc + 3) begin
      n_bad++;
      $display("FAIL single_done: got at +%0d want +3", done_cyc[db] - s_cyc);
    end
    n_cmp++;
    if (ovr_cyc.size() - vb != 1 || ovr_cyc[vb] != s_cyc + 4) begin
      n_bad++;
      $display("FAIL single_out_valid: got rise at +%0d want +4", ovr_cyc[vb] - s_cyc);
    end
    n_cmp++;
    if (pop_dat.size() - pb != 1 || pop_dat[pb] !== 32'd8) begin
      n_bad++;
      $display("FAIL single_data: got %0d pops data %h want 1 pop of 00000008",
               pop_dat.size() - pb, pop_dat[pb]);
    end
    n_cmp++;
    if ({busy, out_valid} !== 2'b0) begin
      n_bad++;
      $display("FAIL single_end: got busy/out_valid %b want 00", {busy, out_valid});
    end
  endtask

  // Shared by test_multi_chunk and test_start_ignored: rows=2, chunks=3.
  task automatic check_2x3(input string tag, input int rb, input int pb, input int db,
                           input logic [31:0] s0, input logic [31:0] s1);
    n_cmp++;
    if (rd_cyc.size() - rb != 6) begin
      n_bad++;
      $display("FAIL %s_rd_count: got %0d want 6", tag, rd_cyc.size() - rb);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (rd_vec[rb+i] != i % 3 || rd_mat[rb+i] != i || rd_cyc[rb+i] != s_cyc + 1 + i) begin
          n_bad++;
          $display("FAIL %s_rd%0d: got vec %0d mat %0d at +%0d want %0d/%0d at +%0d", tag, i,
                   rd_vec[rb+i], rd_mat[rb+i], rd_cyc[rb+i] - s_cyc, i % 3, i, i + 1);
        end
      end
    end
    n_cmp++;
    if (pop_dat.size() - pb != 2 || pop_dat[pb] !== s0 || pop_dat[pb+1] !== s1) begin
      n_bad++;
      $display("FAIL %s_sums: got %0d pops %h %h want %h %h", tag, pop_dat.size() - pb,
               pop_dat[pb], pop_dat[pb+1], s0, s1);
    end
    n_cmp++;
    if (done_cyc.size() - db != 1) begin
      n_bad++;
      $display("FAIL %s_done_count: got %0d want 1", tag, done_cyc.size() - db);
    end
  endtask

  task automatic test_multi_chunk;
    int rb = rd_cyc.size();
    int pb = pop_dat.size();
    int db = done_cyc.size();
    out_ready = 1'b1;
    res_vals.push_back(32'd5);
    res_vals.push_back(-32'sd7);
    res_vals.push_back(32'd100);
    for (int i = 0; i < 3; i++) res_vals.push_back(32'hFFFF_FFFF);
    do_start(2, 3);
    wait_done(db, 60);
    tick(4);
    check_2x3("multi", rb, pb, db, 32'd98, 32'hFFFF_FFFD);
  endtask

  task automatic test_start_ignored;
    int rb = rd_cyc.size();
    int pb = pop_dat.size();
    int db = done_cyc.size();
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) res_vals.push_back(32'(i));
    do_start(2, 3);
    tick(1);
    cfg_rows = 8'd5; cfg_chunks = 6'd1; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(db, 60);
    tick(4);
    check_2x3("ignore", rb, pb, db, 32'd6, 32'd15);
  endtask

  task automatic test_overflow;
    int pb = pop_dat.size();
    int db = done_cyc.size();
    out_ready = 1'b1;
    res_vals.push_back(32'h7FFF_FFFF);
    res_vals.push_back(32'd1);
    do_start(1, 2);
    wait_done(db, 50);
    tick(3);
    n_cmp++;
    if (pop_dat.size() - pb != 1 || pop_dat[pb] !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL overflow: got %0d pops data %h want 80000000", pop_dat.size() - pb,
               pop_dat[pb]);
    end
  endtask

  task automatic test_zero;
    int rb = rd_cyc.size();
    int db = done_cyc.size();
    do_start(0, 3);
    n_cmp++;
    if ({done, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL zero_rows_done: got done/busy %b want 10", {done, busy});
    end
    tick(1);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_rows_pulse: got done %b want 0", done);
    end
    tick(3);
    do_start(3, 0);
    tick(4);
    n_cmp++;
    if (done_cyc.size() - db != 2 || done_cyc[db+1] != s_cyc + 1) begin
      n_bad++;
      $display("FAIL zero_chunks_done: got %0d pulses last at +%0d want 2, +1",
               done_cyc.size() - db, done_cyc[db+1] - s_cyc);
    end
    n_cmp++;
    if (rd_cyc.size() != rb) begin
      n_bad++;
      $display("FAIL zero_no_reads: got %0d reads want 0", rd_cyc.size() - rb);
    end
  endtask

  task automatic test_backpressure;
    int rb = rd_cyc.size();
    int pb = pop_dat.size();
    int db = done_cyc.size();
    logic [31:0] want;
    out_ready = 1'b0;
    for (int r = 0; r < 6; r++) begin
      res_vals.push_back(32'(r * 10 + 1));
      res_vals.push_back(32'(r * 10 + 2));
    end
    do_start(6, 2);
    tick(30);
    n_cmp++;
    if (rd_cyc.size() - rb != 8) begin
      n_bad++;
      $display("FAIL bp_stall_reads: got %0d want 8", rd_cyc.size() - rb);
    end
    n_cmp++;
    if ({rd_en, busy, out_valid} !== 3'b011 || out_data !== 32'd3) begin
      n_bad++;
      $display("FAIL bp_stall_state: got rd/busy/valid %b data %0d want 011 data 3",
               {rd_en, busy, out_valid}, out_data);
    end
    out_ready = 1'b1;
    wait_done(db, 200);
    tick(8);
    n_cmp++;
    if (rd_cyc.size() - rb != 12 || rd_mat[rb+11] != 11) begin
      n_bad++;
      $display("FAIL bp_reads: got %0d reads last mat %0d want 12, 11", rd_cyc.size() - rb,
               rd_mat[rb+11]);
    end
    n_cmp++;
    if (pop_dat.size() - pb != 6) begin
      n_bad++;
      $display("FAIL bp_pop_count: got %0d want 6", pop_dat.size() - pb);
    end else begin
      for (int r = 0; r < 6; r++) begin
        want = 32'(20 * r + 3);
        n_cmp++;
        if (pop_dat[pb+r] !== want) begin
          n_bad++;
          $display("FAIL bp_sum%0d: got %0d want %0d", r, pop_dat[pb+r], want);
        end
      end
    end
    n_cmp++;
    if (done_cyc.size() - db != 1) begin
      n_bad++;
      $display("FAIL bp_done_count: got %0d want 1", done_cyc.size() - db);
    end
  endtask

  task automatic test_back_to_back;
    int pb = pop_dat.size();
    int db = done_cyc.size();
    int rb2;
    int db2;
    out_ready = 1'b0;
    res_vals.push_back(32'd1);
    res_vals.push_back(32'd2);
    do_start(2, 1);
    wait_done(db, 50);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'd1) begin
      n_bad++;
      $display("FAIL b2b_held: got valid %b data %0d want 1, 1", out_valid, out_data);
    end
    for (int i = 3; i <= 5; i++) res_vals.push_back(32'(i));
    rb2 = rd_cyc.size();
    db2 = done_cyc.size();
    do_start(3, 1);
    tick(20);
    n_cmp++;
    if (rd_cyc.size() - rb2 != 2 || rd_cyc[rb2] != s_cyc + 1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_credits: got %0d reads first at +%0d busy %b want 2, +1, 1",
               rd_cyc.size() - rb2, rd_cyc[rb2] - s_cyc, busy);
    end
    out_ready = 1'b1;
    wait_done(db2, 100);
    tick(8);
    n_cmp++;
    if (pop_dat.size() - pb != 5) begin
      n_bad++;
      $display("FAIL b2b_pop_count: got %0d want 5", pop_dat.size() - pb);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (pop_dat[pb+i] !== 32'(i + 1)) begin
          n_bad++;
          $display("FAIL b2b_sum%0d: got %0d want %0d", i, pop_dat[pb+i], i + 1);
        end
      end
    end
  endtask

  task automatic test_reset_midjob;
    int db = done_cyc.size();
    int pb;
    int rb;
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) res_vals.push_back(32'd1);
    do_start(3, 4);
    tick(10);
    n_cmp++;
    if ({out_valid, rd_en, busy} !== 3'b111) begin
      n_bad++;
      $display("FAIL midjob_pre: got valid/rd/busy %b want 111", {out_valid, rd_en, busy});
    end
    rst = 1'b1;
    tick(1);
    n_cmp++;
    if ({busy, done, rd_en, dot_ivalid, out_valid} !== 5'b0 || out_data !== 32'h0 ||
        vec_raddr !== 9'h0 || mat_raddr !== 9'h0) begin
      n_bad++;
      $display("FAIL midjob_reset: got ctrl %b data %h vec %0d mat %0d want all 0",
               {busy, done, rd_en, dot_ivalid, out_valid}, out_data, vec_raddr, mat_raddr);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    tick(1);
    pb = pop_dat.size();
    rb = rd_cyc.size();
    res_vals.push_back(32'd40);
    res_vals.push_back(32'd2);
    do_start(1, 2);
    wait_done(db, 50);
    tick(4);
    n_cmp++;
    if (done_cyc.size() - db != 1) begin
      n_bad++;
      $display("FAIL midjob_done_count: got %0d want 1", done_cyc.size() - db);
    end
    n_cmp++;
    if (pop_dat.size() - pb != 1 || pop_dat[pb] !== 32'd42 || rd_mat[rb] != 0) begin
      n_bad++;
      $display("FAIL midjob_new_job: got %0d pops data %0d mat0 %0d want 1, 42, 0",
               pop_dat.size() - pb, pop_dat[pb], rd_mat[rb]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_chunk();
    test_start_ignored();
    test_overflow();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_midjob();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
